// File: rtl/vid_ctrl_pkg.sv
// Shared types and default constants for the video RAM capture controller.
package vid_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_CAPTURE   = 2'd2
  } vid_state_t;

  localparam int VRAM_ADDR_W       = 15;
  localparam int VRAM_DATA_W       = 8;
  localparam int DEF_LOCK_FRAMES   = 4;
  localparam int DEF_UNLOCK_FRAMES = 3;
  localparam int DEF_LOSS_TO       = 300000;

  // Bits needed to hold the values 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/vram_clear_sweep.sv
// Frame-buffer clear address sweeper: walks 0..2^ADDR_W-1 once per start.
module vram_clear_sweep
  import vid_ctrl_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              dotclk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  // Reset leaves the sweeper running, matching the controller's reset state.
  always_ff @(posedge dotclk) begin
    if (rst || start) begin
      addr <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (done) busy <= 1'b0;
      else      addr <= addr + 1'b1;
    end
  end

  assign done = busy && (addr == '1);

endmodule

// File: rtl/vram_capture_ctrl.sv
// Display RAM port A sequencer: clear engine, sync lock FSM and capture gating.
// Optional VID_FREEZE_ON_LOSS_EN: signal loss in CAPTURE keeps the frame instead of clearing.
module vram_capture_ctrl
  import vid_ctrl_pkg::*;
#(
  parameter int                ADDR_W        = VRAM_ADDR_W,
  parameter int                DATA_W        = VRAM_DATA_W,
  parameter int                LOCK_FRAMES   = DEF_LOCK_FRAMES,
  parameter int                UNLOCK_FRAMES = DEF_UNLOCK_FRAMES,
  parameter int                LOSS_TO       = DEF_LOSS_TO,
  parameter logic [DATA_W-1:0] CLEAR_VAL     = '0
) (
  input  logic              dotclk,
  input  logic              rst,
  input  logic              mode80,
  input  logic              vsync_fall,
  input  logic              frame_ok,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [1:0]        state,
  output logic              locked
);

  localparam int GW = cnt_w(LOCK_FRAMES);
  localparam int BW = cnt_w(UNLOCK_FRAMES);
  localparam int TW = cnt_w(LOSS_TO);
  localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0] UNLOCK_LAST = BW'(UNLOCK_FRAMES - 1);
  localparam logic [TW-1:0] LOSS_LAST   = TW'(LOSS_TO - 1);
  localparam logic [TW-1:0] LOSS_MAX    = TW'(LOSS_TO);

  vid_state_t        state_q, state_n;
  logic [GW-1:0]     good_cnt, good_n;
  logic [BW-1:0]     bad_cnt, bad_n;
  logic [TW-1:0]     to_cnt, to_n;
  logic              mode_q;
  logic              mode_chg, loss;
  logic              sweep_start, sweep_busy, sweep_done;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  vram_clear_sweep #(.ADDR_W(ADDR_W)) u_sweep (
    .dotclk (dotclk),
    .rst    (rst),
    .start  (sweep_start),
    .busy   (sweep_busy),
    .done   (sweep_done),
    .addr   (clr_addr)
  );

  assign mode_chg = (mode80 != mode_q);
  // Loss fires only on the increment that lands on LOSS_TO, so it cannot coincide with vsync_fall.
  assign loss     = !vsync_fall && (to_cnt == LOSS_LAST);

  always_comb begin
    state_n     = state_q;
    good_n      = good_cnt;
    bad_n       = bad_cnt;
    sweep_start = 1'b0;
    if (mode_chg) begin
      state_n     = ST_CLEAR;
      sweep_start = 1'b1;
      good_n      = '0;
      bad_n       = '0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          good_n = '0;
          bad_n  = '0;
          if (sweep_done) state_n = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (loss) begin
            good_n = '0;
          end else if (vsync_fall) begin
            if (!frame_ok) begin
              good_n = '0;
            end else if (good_cnt == LOCK_LAST) begin
              state_n = ST_CAPTURE;
              good_n  = '0;
              bad_n   = '0;
            end else begin
              good_n = good_cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (loss) begin
            good_n = '0;
            bad_n  = '0;
`ifdef VID_FREEZE_ON_LOSS_EN
            state_n = ST_WAIT_SYNC;
`else
            state_n     = ST_CLEAR;
            sweep_start = 1'b1;
`endif
          end else if (vsync_fall) begin
            if (frame_ok) begin
              bad_n = '0;
            end else if (bad_cnt == UNLOCK_LAST) begin
              state_n = ST_WAIT_SYNC;
              good_n  = '0;
              bad_n   = '0;
            end else begin
              bad_n = bad_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n     = ST_CLEAR;
          sweep_start = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    to_n = to_cnt;
    if (mode_chg || vsync_fall) to_n = '0;
    else if (to_cnt != LOSS_MAX) to_n = to_cnt + 1'b1;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == ST_CLEAR && sweep_busy) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = CLEAR_VAL;
    end else if (state_q == ST_CAPTURE && cap_we) begin
      wr_en   = 1'b1;
      wr_addr = cap_addr;
      wr_data = cap_data;
    end
  end

  always_ff @(posedge dotclk) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      good_cnt <= '0;
      bad_cnt  <= '0;
      to_cnt   <= '0;
      mode_q   <= mode80;
      ram_ce   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      state_q  <= state_n;
      good_cnt <= good_n;
      bad_cnt  <= bad_n;
      to_cnt   <= to_n;
      mode_q   <= mode80;
      ram_ce   <= wr_en;
      ram_we   <= wr_en;
      ram_addr <= wr_addr;
      ram_din  <= wr_data;
    end
  end

  assign state  = state_q;
  assign locked = (state_q == ST_CAPTURE);

endmodule
